delay_arbiter: RTL and testbench
================================

# delay_arbiter

Shared tick timer for multiple requesters. Up to N_REQ clients each request a one-shot delay measured in prescaled ticks. One prescaler and one delay counter serve them one at a time, granted in round-robin order, and the owner gets a done pulse when its delay expires. The block sits between the free-running timing logic and the LED/pattern sequencers, so those sequencers no longer each instantiate their own divider.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TICK_MAX, 13500000, prescaler terminal count; one tick = TICK_MAX+1 clk cycles
- DELAY_W, 8, width of each delay request in ticks

Ports:
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i wants a delay
- req_delay  in  N_REQ*DELAY_W  delay for requester i, bits [i*DELAY_W +: DELAY_W]
- req_ready  out  N_REQ  one-hot accept for requester i (combinational from state/pointer/req_valid)
- cancel  in  1  abort the running delay
- done  out  N_REQ  registered one-cycle pulse to the owner on expiry
- busy  out  1  high whenever state != IDLE
- grant_id  out  $clog2(N_REQ)  index of the current/last owner

## Operation
- State machine: IDLE, RUN, DONE.
  - Reset enters IDLE.
  - Reset values: done=0, busy=0, grant_id=0, prescaler=0, remaining=0, last pointer=N_REQ-1. Requester 0 therefore has first priority.
- **IDLE, selection:**
  - The winner is the first i with req_valid[i]=1, searching (last+1) mod N_REQ upward and wrapping.
  - req_ready[winner]=1 in the same cycle. All other req_ready bits are 0.
  - req_ready is 0 in every non-IDLE state and in any cycle where rst=1.
- **IDLE, accept** (valid & ready):
  - Latch remaining <= req_delay[winner] and owner/grant_id <= winner.
  - Update last <= winner and clear prescaler <= 0.
  - Go to RUN.
- **RUN:**
  - If remaining==0: go to DONE.
  - Else the prescaler increments. When prescaler==TICK_MAX: prescaler <= 0 and remaining <= remaining-1 (this is a tick).
  - Prescaler width is $clog2(TICK_MAX+1). The prescaler never exceeds TICK_MAX.
- **DONE:** done[owner]=1 for exactly one cycle, then go to IDLE. A new grant can occur in that following IDLE cycle.
- **cancel:**
  - Sampled in RUN only. It has priority over the remaining==0 check and over a tick in the same cycle.
  - Go to IDLE with no done pulse. The prescaler clears and last is unchanged.
  - cancel is ignored in IDLE and DONE.
- **Delay 0:** legal; produces done with no ticks.
- **Requests while busy:**
  - They are not queued. The requester holds req_valid until it sees req_ready.
  - The block tolerates req_valid dropping before grant; that requester is simply not granted.
- req_delay is sampled only at accept. Later changes have no effect.
- rst mid-RUN or mid-DONE: return to reset values next cycle with no done pulse. A DONE cycle coincident with rst produces no pulse.

## Timing
- Accept in cycle A: busy=1 from A+1.
- done[owner]=1 in cycle A + D*(TICK_MAX+1) + 2, where D is the latched delay. busy=0 the cycle after.
- D=0: done in A+2.
- Back-to-back: minimum accept-to-next-accept is D*(TICK_MAX+1)+3 cycles.
- grant_id is valid from A+1 and holds until the next accept.

## Test plan
- **Reset/idle:** TICK_MAX=3, rst high 3 cycles, no requests -> done=0, busy=0, req_ready=0, grant_id=0 throughout.
- **Single delay:** TICK_MAX=3, req 2 with delay 5, accepted at cycle A -> done[2] pulses exactly at A+22 and no other done bit pulses; busy high A+1..A+22; grant_id=2.
- **Zero delay:** req 1 with delay 0 accepted at A -> done[1] at A+2.
- **Round-robin:** all four req_valid held high, each delay 1, TICK_MAX=3 -> grant order 0,1,2,3,0; each done 6 cycles after its accept; next accept one cycle after each done.
- **Cancel:** req 0, delay 10, cancel pulse mid-RUN at the same cycle prescaler==TICK_MAX -> no done[0]; busy drops next cycle; pending req 1 is granted in the following IDLE cycle.
- **Reset mid-operation:** rst asserted for 1 cycle during RUN -> no done; all outputs return to reset values; the pointer restarts so req 0 wins over req 3 when both are pending.

Source files
------------

// File: rtl/delay_arbiter.sv
// Shared prescaled delay timer: one prescaler and one down-counter serve N_REQ
// requesters one at a time, granted round-robin, with a done pulse to the owner.
module delay_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TICK_MAX = 13500000,
  parameter int DELAY_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DELAY_W-1:0]   req_delay,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       cancel,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PSW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [PSW-1:0] PS_TERM  = PSW'(TICK_MAX);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Handshake: a requester is accepted in the cycle where req_valid[i] and
  // req_ready[i] are both high at the rising edge; req_ready never depends on
  // anything other than state, last pointer, rst and req_valid.
  logic [1:0]         state;
  logic [IDW-1:0]     last_ptr;
  logic [PSW-1:0]     prescaler;
  logic [DELAY_W-1:0] remaining;
  logic [N_REQ-1:0]   done_r;

  logic [IDW-1:0]     winner;
  logic               found;
  logic               accept;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    logic [IDW-1:0] cand;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && !rst && found) begin
      req_ready = N_REQ'(1) << winner;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign busy   = (state != ST_IDLE);

  // A DONE cycle that coincides with rst must not reach the owner.
  always_comb begin
    done = done_r;
    if (rst) begin
      done = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_ptr  <= LAST_RST;
      prescaler <= '0;
      remaining <= '0;
      grant_id  <= '0;
      done_r    <= '0;
    end else begin
      done_r <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            remaining <= req_delay[int'(winner)*DELAY_W +: DELAY_W];
            grant_id  <= winner;
            last_ptr  <= winner;
            prescaler <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // cancel outranks both expiry and a tick landing in the same cycle
          if (cancel) begin
            prescaler <= '0;
            state     <= ST_IDLE;
          end else if (remaining == '0) begin
            done_r <= N_REQ'(1) << grant_id;
            state  <= ST_DONE;
          end else if (prescaler == PS_TERM) begin
            prescaler <= '0;
            remaining <= remaining - DELAY_W'(1);
          end else begin
            prescaler <= prescaler + PSW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with TICK_MAX=3 (4 clk per tick), N_REQ=4.
module tb_delay_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TM = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_delay;
  logic [N-1:0]  req_ready;
  logic          cancel;
  logic [N-1:0]  done;
  logic          busy;
  logic [IW-1:0] grant_id;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] w1h;

  delay_arbiter #(.N_REQ(N), .TICK_MAX(TM), .DELAY_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_delay(req_delay),
    .req_ready(req_ready), .cancel(cancel), .done(done), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_delay(input int i, input logic [DW-1:0] d);
    req_delay[i*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_delay = '0; cancel = 1'b0;
    nxt();

    // Reset and idle
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("rst_done", done, 0); chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0); chk("rst_grant", grant_id, 0);
      nxt();
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("idle_done", done, 0); chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 0); chk("idle_grant", grant_id, 0);
      nxt();
    end

    // Single delay: req 2, D=5 -> done at A+22
    req_valid = 4'b0100; set_delay(2, 8'd5);
    mid(); chk("single_ready", req_ready, 4'b0100); nxt();
    req_valid = '0; set_delay(2, 8'd9);
    mid(); chk("single_grant", grant_id, 2); chk("single_busy1", busy, 1); nxt();
    for (int c = 2; c <= 21; c++) begin
      mid(); chk("single_wait_done", done, 0); chk("single_wait_busy", busy, 1); nxt();
    end
    mid(); chk("single_done", done, 4'b0100); chk("single_busy22", busy, 1); nxt();
    mid(); chk("single_after_done", done, 0); chk("single_after_busy", busy, 0); nxt();

    // Zero delay: req 1 -> done at A+2
    req_valid = 4'b0010; set_delay(1, 8'd0);
    mid(); chk("zero_ready", req_ready, 4'b0010); nxt();
    req_valid = '0;
    mid(); chk("zero_busy", busy, 1); chk("zero_grant", grant_id, 1); chk("zero_nodone", done, 0); nxt();
    mid(); chk("zero_done", done, 4'b0010); nxt();
    mid(); chk("zero_idle", busy, 0); chk("zero_after", done, 0); nxt();

    // Round-robin after a reset (ready stays low while rst is high)
    req_valid = 4'hF; rst = 1'b1;
    for (int i = 0; i < N; i++) set_delay(i, 8'd1);
    mid(); chk("rr_rst_ready", req_ready, 0); nxt();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w1h = 4'b0001 << (k % 4);
      mid(); chk("rr_ready", req_ready, w1h); nxt();
      mid(); chk("rr_grant", grant_id, k % 4); chk("rr_busy", busy, 1); nxt();
      for (int c = 2; c <= 5; c++) begin
        mid(); chk("rr_wait_done", done, 0); chk("rr_wait_ready", req_ready, 0); nxt();
      end
      mid(); chk("rr_done", done, w1h); chk("rr_done_ready", req_ready, 0); nxt();
      if (k == 4) req_valid = '0;
    end
    mid(); chk("rr_end_busy", busy, 0); chk("rr_end_ready", req_ready, 0); nxt();

    // Cancel on the tick cycle (prescaler==TICK_MAX at A+4)
    req_valid = 4'b0001; set_delay(0, 8'd10); set_delay(1, 8'd0);
    mid(); chk("cx_ready", req_ready, 4'b0001); nxt();
    req_valid = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      mid(); chk("cx_run_busy", busy, 1); chk("cx_run_ready", req_ready, 0); nxt();
    end
    cancel = 1'b1;
    mid(); chk("cx_cancel_busy", busy, 1); chk("cx_cancel_done", done, 0); nxt();
    cancel = 1'b0;
    mid(); chk("cx_idle_busy", busy, 0); chk("cx_nodone", done, 0);
    chk("cx_next_ready", req_ready, 4'b0010); nxt();
    req_valid = '0;
    mid(); chk("cx_next_grant", grant_id, 1); chk("cx_next_busy", busy, 1); nxt();
    cancel = 1'b1;
    mid(); chk("cx_done_ignores_cancel", done, 4'b0010); nxt();
    cancel = 1'b0;
    mid(); chk("cx_final_busy", busy, 0); chk("cx_final_done", done, 0); nxt();

    // Reset mid-RUN, then reset coincident with a DONE cycle
    req_valid = 4'b1000; set_delay(3, 8'd2); set_delay(0, 8'd0);
    mid(); chk("rm_ready", req_ready, 4'b1000); nxt();
    req_valid = 4'b1001;
    mid(); chk("rm_grant", grant_id, 3); nxt();
    mid(); chk("rm_busy", busy, 1); nxt();
    rst = 1'b1;
    mid(); chk("rm_rst_ready", req_ready, 0); chk("rm_rst_done", done, 0); nxt();
    rst = 1'b0;
    mid(); chk("rm_after_busy", busy, 0); chk("rm_after_grant", grant_id, 0);
    chk("rm_after_done", done, 0); chk("rm_ptr_restart", req_ready, 4'b0001); nxt();
    req_valid = '0;
    mid(); chk("rm_grant0", grant_id, 0); chk("rm_busy0", busy, 1); nxt();
    rst = 1'b1;
    mid(); chk("rm_done_masked", done, 0); nxt();
    rst = 1'b0;
    mid(); chk("rm_end_busy", busy, 0); chk("rm_end_done", done, 0);
    chk("rm_end_grant", grant_id, 0); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
